stc_payload_sched: RTL and testbench

STC_PAYLOAD_SCHED -- requirements
Module: stc_payload_sched

---
 rtl/stc_pkg.sv | 27 ++
 rtl/stc_bit_fifo.sv | 57 +++++
 rtl/stc_payload_sched.sv | 113 +++++++++++
 tb/tb_stc_payload_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stc_pkg.sv
// Shared constants, source/state enums and the PN15 step function for the
// STC payload scheduler.
package stc_pkg;

  localparam int          STC_GROUP_BITS = 4;
  localparam int          STC_FIFO_DEPTH = 8;
  localparam logic [14:0] STC_PN_SEED    = 15'h7FFF;
  localparam int          STC_PN_TAP_A   = 14;
  localparam int          STC_PN_TAP_B   = 13;

  typedef enum logic {
    SRC_FILL = 1'b0,
    SRC_DATA = 1'b1
  } stc_src_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DATA = 2'd2
  } stc_state_e;

  // x^15 + x^14 + 1, output taken from bit 14 before the shift
  function automatic logic [14:0] pnStep(input logic [14:0] pn);
    return {pn[13:0], pn[STC_PN_TAP_A] ^ pn[STC_PN_TAP_B]};
  endfunction

endpackage

// File: rtl/stc_bit_fifo.sv
// 8-deep 1-bit FIFO with push/pop/head/count; pointers and count are
// cleared by the asynchronous reset.
module stc_bit_fifo
  import stc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic       pushBit_i,
  input  logic       pop_i,
  output logic       head_o,
  output logic [3:0] count_o
);

  localparam int PTR_W = $clog2(STC_FIFO_DEPTH);

  logic             mem_q [STC_FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [3:0]       count_q, count_d;
  logic             pushOk, popOk;

  // Guards keep the pointers consistent even if a caller misbehaves.
  assign pushOk = push_i && (count_q < 4'(STC_FIFO_DEPTH));
  assign popOk  = pop_i && (count_q != 4'd0);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushOk) wrPtr_d = PTR_W'(wrPtr_q + 1);
    if (popOk)  rdPtr_d = PTR_W'(rdPtr_q + 1);
    if (pushOk && !popOk)      count_d = count_q + 4'd1;
    else if (!pushOk && popOk) count_d = count_q - 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (pushOk) mem_q[wrPtr_q] <= pushBit_i;
  end

  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/stc_payload_sched.sv
// STC payload scheduler: chooses user data or PN15 fill per 4-bit STC group.
// Optional saturating fill-group statistics enabled by STC_SCHED_STATS_EN.
module stc_payload_sched
  import stc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clkEn,
  input  logic        enable,
  input  logic        srcBit,
  input  logic        srcValid,
  output logic        srcReady,
  input  logic        payloadBitEn,
  output logic        payloadBit,
  output logic        fillActive,
  output logic [3:0]  fifoCount,
  output logic [15:0] fillGroups
);

  localparam int IDX_W = $clog2(STC_GROUP_BITS);

  stc_state_e       state_q, state_d;
  stc_src_e         grpSel_q, grpSel_d;
  logic [IDX_W-1:0] bitIdx_q, bitIdx_d;
  logic [14:0]      pn_q, pn_d;
  logic             fillActive_q, fillActive_d;

  logic     consume, groupStart, launch, push, pop, fifoHead;
  stc_src_e decideSrc, effSrc;

  assign consume    = clkEn & payloadBitEn;
  assign groupStart = (bitIdx_q == '0);
  assign launch     = consume && (groupStart || state_q == ST_IDLE);
  assign srcReady   = (fifoCount < 4'(STC_FIFO_DEPTH));
  assign push       = srcValid & srcReady;

  // A full group must already be buffered, so a DATA group cannot underflow.
  assign decideSrc = (enable && fifoCount >= 4'(STC_GROUP_BITS)) ? SRC_DATA : SRC_FILL;
  assign effSrc    = groupStart ? decideSrc : grpSel_q;
  assign pop       = consume && (effSrc == SRC_DATA);

  assign payloadBit = (effSrc == SRC_DATA) ? fifoHead : pn_q[STC_PN_TAP_A];
  assign fillActive = fillActive_q;

  stc_bit_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .pushBit_i (srcBit),
    .pop_i     (pop),
    .head_o    (fifoHead),
    .count_o   (fifoCount)
  );

  always_comb begin
    state_d      = state_q;
    grpSel_d     = grpSel_q;
    bitIdx_d     = bitIdx_q;
    pn_d         = pn_q;
    fillActive_d = fillActive_q;

    if (consume) begin
      bitIdx_d = IDX_W'(bitIdx_q + 1);
      if (effSrc == SRC_FILL) pn_d = pnStep(pn_q);
    end

    unique case (state_q)
      ST_IDLE, ST_FILL, ST_DATA: begin
        if (launch) begin
          state_d      = (decideSrc == SRC_DATA) ? ST_DATA : ST_FILL;
          grpSel_d     = decideSrc;
          fillActive_d = (decideSrc == SRC_FILL);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grpSel_q     <= SRC_FILL;
      bitIdx_q     <= '0;
      pn_q         <= STC_PN_SEED;
      fillActive_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grpSel_q     <= grpSel_d;
      bitIdx_q     <= bitIdx_d;
      pn_q         <= pn_d;
      fillActive_q <= fillActive_d;
    end
  end

`ifdef STC_SCHED_STATS_EN
  logic [15:0] fillGroups_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fillGroups_q <= '0;
    end else if (launch && decideSrc == SRC_FILL && fillGroups_q != 16'hFFFF) begin
      fillGroups_q <= fillGroups_q + 16'd1;
    end
  end

  assign fillGroups = fillGroups_q;
`else
  assign fillGroups = 16'h0000;
`endif

  noEmptyPop: assert property (@(posedge clk) disable iff (reset) !(pop && fifoCount == 4'd0));

endmodule

// File: tb/tb_stc_payload_sched.sv
// Directed self-checking bench for stc_payload_sched; expected fillGroups
// values follow STC_SCHED_STATS_EN when the bench is built with it.
module tb_stc_payload_sched;

`ifdef STC_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clkEn = 1'b0;
  logic        enable = 1'b0;
  logic        srcBit = 1'b0;
  logic        srcValid = 1'b0;
  logic        payloadBitEn = 1'b0;
  logic        srcReady;
  logic        payloadBit;
  logic        fillActive;
  logic [3:0]  fifoCount;
  logic [15:0] fillGroups;

  int errors = 0;
  int checks = 0;

  stc_payload_sched dut (
    .clk          (clk),
    .reset        (reset),
    .clkEn        (clkEn),
    .enable       (enable),
    .srcBit       (srcBit),
    .srcValid     (srcValid),
    .srcReady     (srcReady),
    .payloadBitEn (payloadBitEn),
    .payloadBit   (payloadBit),
    .fillActive   (fillActive),
    .fifoCount    (fifoCount),
    .fillGroups   (fillGroups)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [15:0] expFg(input int n);
    return STATS ? 16'(n) : 16'h0000;
  endfunction

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1; clkEn = 1'b0; payloadBitEn = 1'b0; srcValid = 1'b0; srcBit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pushBit(input logic b);
    @(negedge clk);
    srcBit = b; srcValid = 1'b1;
    @(posedge clk);
    #1 srcValid = 1'b0;
  endtask

  // One consume, optionally with a push attempt on the same edge.
  task automatic consumeBit(input logic doPush, input logic b, output logic obs);
    @(negedge clk);
    clkEn = 1'b1; payloadBitEn = 1'b1; srcValid = doPush; srcBit = b;
    #1 obs = payloadBit;
    @(posedge clk);
    #1 clkEn = 1'b0; payloadBitEn = 1'b0; srcValid = 1'b0;
  endtask

  task automatic test_reset();
    applyReset();
    #1;
    checks++; if (fifoCount !== 4'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", fifoCount); end
    checks++; if (srcReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", srcReady); end
    checks++; if (fillActive !== 1'b1) begin errors++; $display("[TB] FAIL reset_fill got=%b exp=1", fillActive); end
    checks++; if (fillGroups !== 16'h0000) begin errors++; $display("[TB] FAIL reset_fg got=%h exp=0000", fillGroups); end
    checks++; if (payloadBit !== 1'b1) begin errors++; $display("[TB] FAIL reset_bit got=%b exp=1", payloadBit); end
  endtask

  task automatic test_fill_only();
    logic obs;
    applyReset();
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      consumeBit(1'b0, 1'b0, obs);
      checks++; if (obs !== 1'b1) begin errors++; $display("[TB] FAIL fill_bit%0d got=%b exp=1", i, obs); end
    end
    checks++; if (fillActive !== 1'b1) begin errors++; $display("[TB] FAIL fill_active got=%b exp=1", fillActive); end
    checks++; if (fillGroups !== expFg(2)) begin errors++; $display("[TB] FAIL fill_groups got=%h exp=%h", fillGroups, expFg(2)); end
  endtask

  task automatic test_data_group();
    logic obs;
    logic [3:0] pat;
    pat = 4'b1011;
    applyReset();
    enable = 1'b1;
    for (int i = 3; i >= 0; i--) pushBit(pat[i]);
    checks++; if (fifoCount !== 4'd4) begin errors++; $display("[TB] FAIL data_fill_count got=%0d exp=4", fifoCount); end
    for (int i = 0; i < 4; i++) begin
      consumeBit(1'b0, 1'b0, obs);
      checks++; if (obs !== pat[3-i]) begin errors++; $display("[TB] FAIL data_bit%0d got=%b exp=%b", i, obs, pat[3-i]); end
      checks++; if (fifoCount !== 4'(3-i)) begin errors++; $display("[TB] FAIL data_count%0d got=%0d exp=%0d", i, fifoCount, 3-i); end
      if (i == 0) begin
        checks++; if (fillActive !== 1'b0) begin errors++; $display("[TB] FAIL data_active got=%b exp=0", fillActive); end
      end
    end
    checks++; if (fillGroups !== expFg(0)) begin errors++; $display("[TB] FAIL data_groups got=%h exp=%h", fillGroups, expFg(0)); end
  endtask

  task automatic test_partial_group();
    logic obs;
    logic [3:0] exp2;
    exp2 = 4'b1100;
    applyReset();
    enable = 1'b1;
    pushBit(1'b1); pushBit(1'b1); pushBit(1'b0);
    for (int i = 0; i < 4; i++) begin
      consumeBit(1'b0, 1'b0, obs);
      checks++; if (obs !== 1'b1) begin errors++; $display("[TB] FAIL partial_fill%0d got=%b exp=1", i, obs); end
    end
    checks++; if (fifoCount !== 4'd3) begin errors++; $display("[TB] FAIL partial_count got=%0d exp=3", fifoCount); end
    checks++; if (fillActive !== 1'b1) begin errors++; $display("[TB] FAIL partial_active got=%b exp=1", fillActive); end
    pushBit(1'b0);
    for (int i = 0; i < 4; i++) begin
      consumeBit(1'b0, 1'b0, obs);
      checks++; if (obs !== exp2[3-i]) begin errors++; $display("[TB] FAIL partial_data%0d got=%b exp=%b", i, obs, exp2[3-i]); end
    end
    checks++; if (fillActive !== 1'b0) begin errors++; $display("[TB] FAIL partial_data_active got=%b exp=0", fillActive); end
    checks++; if (fifoCount !== 4'd0) begin errors++; $display("[TB] FAIL partial_end_count got=%0d exp=0", fifoCount); end
    checks++; if (fillGroups !== expFg(1)) begin errors++; $display("[TB] FAIL partial_groups got=%h exp=%h", fillGroups, expFg(1)); end
  endtask

  // PN bits 12..15 from seed 7FFF are 1,1,1,0; a data group in between must not advance it.
  task automatic test_pn_phase();
    logic obs;
    logic [3:0] expPn;
    expPn = 4'b1110;
    applyReset();
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      consumeBit(1'b0, 1'b0, obs);
      checks++; if (obs !== 1'b1) begin errors++; $display("[TB] FAIL pn_head%0d got=%b exp=1", i, obs); end
    end
    for (int i = 0; i < 4; i++) pushBit(1'b0);
    for (int i = 0; i < 4; i++) begin
      consumeBit(1'b0, 1'b0, obs);
      checks++; if (obs !== 1'b0) begin errors++; $display("[TB] FAIL pn_data%0d got=%b exp=0", i, obs); end
    end
    for (int i = 0; i < 4; i++) begin
      consumeBit(1'b0, 1'b0, obs);
      checks++; if (obs !== expPn[3-i]) begin errors++; $display("[TB] FAIL pn_resume%0d got=%b exp=%b", i, obs, expPn[3-i]); end
    end
    checks++; if (fillGroups !== expFg(4)) begin errors++; $display("[TB] FAIL pn_groups got=%h exp=%h", fillGroups, expFg(4)); end
  endtask

  task automatic test_full_fifo();
    logic obs;
    logic [7:0] pat;
    logic [3:0] tail;
    logic [3:0] expCnt;
    pat = 8'b1001_1010;
    tail = 4'b1000;
    expCnt = 4'd7;
    applyReset();
    enable = 1'b1;
    for (int i = 7; i >= 0; i--) pushBit(pat[i]);
    checks++; if (fifoCount !== 4'd8) begin errors++; $display("[TB] FAIL full_count got=%0d exp=8", fifoCount); end
    checks++; if (srcReady !== 1'b0) begin errors++; $display("[TB] FAIL full_ready got=%b exp=0", srcReady); end
    pushBit(1'b1);
    checks++; if (fifoCount !== 4'd8) begin errors++; $display("[TB] FAIL full_reject got=%0d exp=8", fifoCount); end
    for (int i = 0; i < 8; i++) begin
      consumeBit(i < 2, 1'b1, obs);
      checks++; if (obs !== pat[7-i]) begin errors++; $display("[TB] FAIL full_bit%0d got=%b exp=%b", i, obs, pat[7-i]); end
      if (i == 0 || i == 1) begin
        checks++; if (fifoCount !== expCnt) begin errors++; $display("[TB] FAIL full_pushpop%0d got=%0d exp=%0d", i, fifoCount, expCnt); end
      end
    end
    checks++; if (fifoCount !== 4'd1) begin errors++; $display("[TB] FAIL full_after got=%0d exp=1", fifoCount); end
    for (int i = 0; i < 3; i++) pushBit(1'b0);
    for (int i = 0; i < 4; i++) begin
      consumeBit(1'b0, 1'b0, obs);
      checks++; if (obs !== tail[3-i]) begin errors++; $display("[TB] FAIL full_tail%0d got=%b exp=%b", i, obs, tail[3-i]); end
    end
    checks++; if (srcReady !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_end got=%b exp=1", srcReady); end
  endtask

  task automatic test_enable_drop();
    logic obs;
    logic [7:0] pat;
    pat = 8'b0110_0000;
    applyReset();
    enable = 1'b1;
    for (int i = 7; i >= 0; i--) pushBit(pat[i]);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) enable = 1'b0;
      consumeBit(1'b0, 1'b0, obs);
      checks++; if (obs !== pat[7-i]) begin errors++; $display("[TB] FAIL drop_bit%0d got=%b exp=%b", i, obs, pat[7-i]); end
    end
    checks++; if (fifoCount !== 4'd4) begin errors++; $display("[TB] FAIL drop_count got=%0d exp=4", fifoCount); end
    checks++; if (fillActive !== 1'b0) begin errors++; $display("[TB] FAIL drop_active got=%b exp=0", fillActive); end
    for (int i = 0; i < 4; i++) begin
      consumeBit(1'b0, 1'b0, obs);
      checks++; if (obs !== 1'b1) begin errors++; $display("[TB] FAIL drop_fill%0d got=%b exp=1", i, obs); end
    end
    checks++; if (fifoCount !== 4'd4) begin errors++; $display("[TB] FAIL drop_fill_count got=%0d exp=4", fifoCount); end
    checks++; if (fillActive !== 1'b1) begin errors++; $display("[TB] FAIL drop_fill_active got=%b exp=1", fillActive); end
  endtask

  task automatic test_pause();
    logic obs;
    logic [7:0] pat;
    pat = 8'b1001_0000;
    applyReset();
    enable = 1'b1;
    for (int i = 7; i >= 0; i--) pushBit(pat[i]);
    for (int i = 0; i < 2; i++) begin
      consumeBit(1'b0, 1'b0, obs);
      checks++; if (obs !== pat[7-i]) begin errors++; $display("[TB] FAIL pause_pre%0d got=%b exp=%b", i, obs, pat[7-i]); end
    end
    @(negedge clk); clkEn = 1'b1; payloadBitEn = 1'b0; enable = 1'b0;
    @(negedge clk); @(negedge clk); clkEn = 1'b0; payloadBitEn = 1'b1;
    @(negedge clk); @(negedge clk); payloadBitEn = 1'b0;
    checks++; if (fifoCount !== 4'd6) begin errors++; $display("[TB] FAIL pause_count got=%0d exp=6", fifoCount); end
    for (int i = 2; i < 4; i++) begin
      consumeBit(1'b0, 1'b0, obs);
      checks++; if (obs !== pat[7-i]) begin errors++; $display("[TB] FAIL pause_post%0d got=%b exp=%b", i, obs, pat[7-i]); end
    end
    checks++; if (fifoCount !== 4'd4) begin errors++; $display("[TB] FAIL pause_end_count got=%0d exp=4", fifoCount); end
  endtask

  task automatic test_reset_mid_group();
    logic obs;
    applyReset();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) pushBit(1'b0);
    consumeBit(1'b0, 1'b0, obs);
    checks++; if (obs !== 1'b0) begin errors++; $display("[TB] FAIL mid_first got=%b exp=0", obs); end
    @(negedge clk); reset = 1'b1;
    #2;
    checks++; if (fifoCount !== 4'd0) begin errors++; $display("[TB] FAIL mid_count got=%0d exp=0", fifoCount); end
    checks++; if (srcReady !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready got=%b exp=1", srcReady); end
    checks++; if (fillActive !== 1'b1) begin errors++; $display("[TB] FAIL mid_active got=%b exp=1", fillActive); end
    @(negedge clk); reset = 1'b0;
    consumeBit(1'b0, 1'b0, obs);
    checks++; if (obs !== 1'b1) begin errors++; $display("[TB] FAIL mid_restart got=%b exp=1", obs); end
    for (int i = 0; i < 4; i++) pushBit(1'b0);
    for (int i = 0; i < 3; i++) begin
      consumeBit(1'b0, 1'b0, obs);
      checks++; if (obs !== 1'b1) begin errors++; $display("[TB] FAIL mid_fill%0d got=%b exp=1", i, obs); end
    end
    checks++; if (fifoCount !== 4'd4) begin errors++; $display("[TB] FAIL mid_hold_count got=%0d exp=4", fifoCount); end
    consumeBit(1'b0, 1'b0, obs);
    checks++; if (obs !== 1'b0) begin errors++; $display("[TB] FAIL mid_data got=%b exp=0", obs); end
    checks++; if (fillActive !== 1'b0) begin errors++; $display("[TB] FAIL mid_data_active got=%b exp=0", fillActive); end
    checks++; if (fillGroups !== expFg(1)) begin errors++; $display("[TB] FAIL mid_groups got=%h exp=%h", fillGroups, expFg(1)); end
  endtask

  initial begin
    $display("[TB] start, stats=%0d", STATS);
    test_reset();
    test_fill_only();
    test_data_group();
    test_partial_group();
    test_pn_phase();
    test_full_fifo();
    test_enable_drop();
    test_pause();
    test_reset_mid_group();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
